// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared encodings for the multdiv scheduler
package multdiv_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [31:0] EXC_MUL = 32'd4;
  localparam logic [31:0] EXC_DIV = 32'd5;

endpackage

// File: rtl/multdiv_scheduler_if.sv
// rtl/multdiv_scheduler_if.sv - scheduler to multiplier/divider unit handshake
interface multdiv_scheduler_if;

  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_ready;

  modport master (
    output ctrl_MULT, ctrl_DIV, md_a, md_b,
    input  md_result, md_exception, md_ready
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, md_a, md_b,
    output md_result, md_exception, md_ready
  );

endinterface

// File: rtl/multdiv_scheduler_md_decode.sv
// rtl/multdiv_scheduler_md_decode.sv - recognises R-type mul/div in the D/X latch
module md_decode
  import multdiv_pkg::*;
(
  input  logic [31:0] insn,
  output logic        is_md,
  output logic        is_div,
  output logic [4:0]  rd
);

  logic rtype;
  logic unused_bits;

  assign rtype  = (insn[31:27] == OP_RTYPE);
  assign is_div = rtype && (insn[6:2] == ALU_DIV);
  assign is_md  = rtype && ((insn[6:2] == ALU_MUL) || (insn[6:2] == ALU_DIV));
  assign rd     = insn[26:22];

  assign unused_bits = ^{insn[21:7], insn[1:0]};

endmodule

// File: rtl/multdiv_scheduler.sv
// rtl/multdiv_scheduler.sv - sequences the shared multiplier/divider for R-type mul/div
module multdiv_scheduler
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         dx_insn,
  input  logic [31:0]         dx_a,
  input  logic [31:0]         dx_b,
  input  logic                kill,
  multdiv_scheduler_if.master md,
  output logic                stall,
  output logic                result_valid,
  output logic [31:0]         result,
  output logic [4:0]          result_rd,
  output logic                exc_valid,
  output logic [31:0]         exc_code
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             op_div;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [4:0]       rd_q;
  logic [31:0]      res_q;
  logic             exc_q;
  logic [31:0]      code_q;

  logic             is_md;
  logic             is_div;
  logic [4:0]       dec_rd;
  logic             detect;

  md_decode u_decode (
    .insn   (dx_insn),
    .is_md  (is_md),
    .is_div (is_div),
    .rd     (dec_rd)
  );

  // The freeze must take effect in the detect cycle itself, before any flop changes.
  assign detect = (state == ST_IDLE) && is_md && !kill && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_div <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      rd_q   <= '0;
      res_q  <= '0;
      exc_q  <= 1'b0;
      code_q <= '0;
    end else if (kill) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_md) begin
            a_q    <= dx_a;
            b_q    <= dx_b;
            rd_q   <= dec_rd;
            op_div <= is_div;
            state  <= ST_START;
          end
        end
        ST_START: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
          if (md.md_ready) begin
            res_q  <= md.md_result;
            exc_q  <= md.md_exception;
            code_q <= md.md_exception ? (op_div ? EXC_DIV : EXC_MUL) : 32'd0;
            state  <= ST_DONE;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // A unit that never answers is reported like a divide error.
            res_q  <= '0;
            exc_q  <= 1'b1;
            code_q <= EXC_DIV;
            state  <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign stall        = detect || (state == ST_START) || (state == ST_WAIT);
  assign md.ctrl_MULT = (state == ST_START) && !op_div && !kill;
  assign md.ctrl_DIV  = (state == ST_START) &&  op_div && !kill;
  assign md.md_a      = a_q;
  assign md.md_b      = b_q;
  assign result_valid = (state == ST_DONE) && !kill;
  assign exc_valid    = result_valid && exc_q;
  assign exc_code     = exc_valid ? code_q : 32'd0;
  assign result       = res_q;
  assign result_rd    = rd_q;

endmodule
